// File: rtl/reverse_burst_if.sv
// Handshake bundle for reverse_burst: valid/ready input stream and valid/ready output stream.
interface reverse_burst_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_swap;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, in_swap, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_swap, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/reverse_burst.sv
// Burst order reverser: fills a stack with up to D words, then drains it LIFO,
// optionally reversing the G-bit groups of every word in the burst.
module reverse_burst #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 16,
  parameter int unsigned G = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  reverse_burst_if.slave bus
);
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned NG = W / G;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_swap;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic [W-1:0]    r_stack [D];

  logic            w_accept;
  logic            w_take;
  logic            w_burst_end;
  logic [CW-1:0]   w_count_m1;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [W-1:0]    w_rd_word;
  logic [W-1:0]    w_rd_rev;

  assign w_accept    = r_in_ready && bus.in_valid;
  assign w_take      = r_out_valid && bus.out_ready;
  assign w_count_m1  = r_count - CW'(1);
  assign w_wr_idx    = r_count[AW-1:0];
  assign w_rd_idx    = w_count_m1[AW-1:0];
  // A full stack closes the burst even without in_last.
  assign w_burst_end = bus.in_last || (r_count == CW'(D - 1));

  always_comb begin
    w_rd_word = r_stack[w_rd_idx];
    w_rd_rev  = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_rd_rev[k*G +: G] = w_rd_word[(NG-1-k)*G +: G];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_stack[w_wr_idx] <= bus.in_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_swap      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_count <= r_count + CW'(1);
            if (r_count == '0) begin
              r_swap <= bus.in_swap;
            end
            if (w_burst_end) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= (r_count == '0);
            end
          end
        end
        DRAIN: begin
          if (w_take) begin
            r_count    <= w_count_m1;
            r_out_last <= (r_count == CW'(2));
            if (r_out_last) begin
              r_state     <= FILL;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  // Ready is held low combinationally for the whole time reset is asserted.
  assign bus.in_ready  = r_in_ready && !i_rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_swap ? w_rd_rev : w_rd_word;
endmodule

// File: tb/tb_reverse_burst.sv
// Randomised self-checking bench for reverse_burst; a G=1 and a G=4 instance share one stimulus stream.
module tb_reverse_burst;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] s_data [$];
  logic       s_last [$];
  logic       s_swap [$];
  logic [7:0] e1 [$];
  logic [7:0] e4 [$];
  logic       el [$];

  reverse_burst_if #(.W(8)) b1 ();
  reverse_burst_if #(.W(8)) b4 ();

  assign b4.in_valid  = b1.in_valid;
  assign b4.in_data   = b1.in_data;
  assign b4.in_last   = b1.in_last;
  assign b4.in_swap   = b1.in_swap;
  assign b4.out_ready = b1.out_ready;

  reverse_burst #(.W(8), .D(DEPTH), .G(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  reverse_burst #(.W(8), .D(DEPTH), .G(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] grev(input logic [7:0] x, input int g);
    int ng;
    int r;
    int grp;
    ng = 8 / g;
    r  = 0;
    for (int k = 0; k < ng; k++) begin
      grp = (int'(x) >> (k * g)) & ((1 << g) - 1);
      r   = r | (grp << ((ng - 1 - k) * g));
    end
    return r[7:0];
  endfunction

  task automatic clear_stim();
    s_data.delete();
    s_last.delete();
    s_swap.delete();
  endtask

  task automatic add(input logic [7:0] d, input logic l, input logic s);
    s_data.push_back(d);
    s_last.push_back(l);
    s_swap.push_back(s);
  endtask

  // Reference: split the stream into bursts (in_last or DEPTH words), emit each reversed.
  task automatic build_expect();
    logic [7:0] burst [$];
    logic       sw;
    e1.delete();
    e4.delete();
    el.delete();
    sw = 1'b0;
    for (int i = 0; i < s_data.size(); i++) begin
      if (burst.size() == 0) sw = s_swap[i];
      burst.push_back(s_data[i]);
      if (s_last[i] || burst.size() == DEPTH) begin
        for (int j = burst.size() - 1; j >= 0; j--) begin
          e1.push_back(sw ? grev(burst[j], 1) : burst[j]);
          e4.push_back(sw ? grev(burst[j], 4) : burst[j]);
          el.push_back(j == 0);
        end
        burst.delete();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.in_swap = 1'b0;
    b1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({b1.in_ready, b1.out_valid, b1.out_last, b4.out_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: got rdy/vld/last/vld4=%b want 0000",
               {b1.in_ready, b1.out_valid, b1.out_last, b4.out_valid});
    end
    rst = 1'b0;
    #1;
    total++;
    if (b1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", b1.in_ready);
    end
    @(negedge clk);
    total++;
    if ({b1.in_ready, b1.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_idle: got rdy/vld=%b want 10", {b1.in_ready, b1.out_valid});
    end
  endtask

  // Cycle-exact single burst with out_ready held high.
  task automatic test_latency(input string nm);
    build_expect();
    b1.out_ready = 1'b1;
    for (int i = 0; i < s_data.size(); i++) begin
      @(negedge clk);
      b1.in_valid = 1'b1; b1.in_data = s_data[i]; b1.in_last = s_last[i]; b1.in_swap = s_swap[i];
      total++;
      if (b1.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s in_ready word %0d: got %b want 1", nm, i, b1.in_ready);
      end
    end
    @(negedge clk);
    b1.in_valid = 1'b0;
    for (int j = 0; j < e1.size(); j++) begin
      total++;
      if ({b1.in_ready, b1.out_valid} !== 2'b01) begin
        bad++;
        $display("FAIL %s drain_state %0d: got rdy/vld=%b want 01", nm, j, {b1.in_ready, b1.out_valid});
      end
      total++;
      if ({b1.out_data, b4.out_data, b1.out_last} !== {e1[j], e4[j], el[j]}) begin
        bad++;
        $display("FAIL %s out %0d: got d1=%h d4=%h last=%b want d1=%h d4=%h last=%b",
                 nm, j, b1.out_data, b4.out_data, b1.out_last, e1[j], e4[j], el[j]);
      end
      @(negedge clk);
    end
    total++;
    if ({b1.in_ready, b1.out_valid, b1.out_last} !== 3'b100) begin
      bad++;
      $display("FAIL %s back_to_fill: got rdy/vld/last=%b want 100",
               nm, {b1.in_ready, b1.out_valid, b1.out_last});
    end
    b1.out_ready = 1'b0;
  endtask

  // Free-running stream: sender and sink run concurrently, sink uses random backpressure.
  task automatic run_stream(input string nm, input int pct, input int stall_idx);
    build_expect();
    fork
      begin : sender
        int tmo;
        for (int i = 0; i < s_data.size(); i++) begin
          @(negedge clk);
          b1.in_valid = 1'b1; b1.in_data = s_data[i]; b1.in_last = s_last[i]; b1.in_swap = s_swap[i];
          tmo = 0;
          while (b1.in_ready !== 1'b1 && tmo < 2000) begin
            @(negedge clk);
            tmo++;
          end
          if (tmo >= 2000) begin
            total++; bad++;
            $display("FAIL %s send_timeout word %0d: got no in_ready want in_ready", nm, i);
            break;
          end
        end
        @(negedge clk);
        b1.in_valid = 1'b0;
      end
      begin : sink
        int idx;
        int cyc;
        int stall_left;
        logic hold;
        logic [7:0] p1, p4;
        logic pl;
        idx = 0; cyc = 0; stall_left = 5; hold = 1'b0;
        p1 = '0; p4 = '0; pl = 1'b0;
        while (idx < e1.size() && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          if (hold) begin
            total++;
            if ({b1.out_valid, b1.out_data, b4.out_data, b1.out_last} !== {1'b1, p1, p4, pl}) begin
              bad++;
              $display("FAIL %s stall_stable: got v=%b d1=%h d4=%h l=%b want v=1 d1=%h d4=%h l=%b",
                       nm, b1.out_valid, b1.out_data, b4.out_data, b1.out_last, p1, p4, pl);
            end
          end
          if (idx == stall_idx && stall_left > 0 && b1.out_valid === 1'b1) begin
            b1.out_ready = 1'b0;
            stall_left--;
          end else begin
            b1.out_ready = ($urandom_range(99) < pct);
          end
          if (b1.out_valid === 1'b1 && b1.out_ready) begin
            total++;
            if ({b1.out_data, b4.out_data, b1.out_last} !== {e1[idx], e4[idx], el[idx]}) begin
              bad++;
              $display("FAIL %s out %0d: got d1=%h d4=%h last=%b want d1=%h d4=%h last=%b",
                       nm, idx, b1.out_data, b4.out_data, b1.out_last, e1[idx], e4[idx], el[idx]);
            end
            idx++;
            hold = 1'b0;
          end else begin
            hold = (b1.out_valid === 1'b1);
            p1 = b1.out_data; p4 = b4.out_data; pl = b1.out_last;
          end
        end
        if (idx < e1.size()) begin
          total++; bad++;
          $display("FAIL %s recv_timeout: got %0d words want %0d", nm, idx, e1.size());
        end
        @(negedge clk);
        b1.out_ready = 1'b0;
        total++;
        if ({b1.out_valid, b1.in_ready} !== 2'b01) begin
          bad++;
          $display("FAIL %s stream_end: got vld/rdy=%b want 01", nm, {b1.out_valid, b1.in_ready});
        end
      end
    join
  endtask

  task automatic test_basic();
    clear_stim();
    add(8'd3, 1'b0, 1'b0); add(8'd1, 1'b0, 1'b0); add(8'd4, 1'b1, 1'b0);
    test_latency("basic");
  endtask

  task automatic test_swap();
    clear_stim();
    add(8'd3, 1'b0, 1'b1); add(8'd1, 1'b0, 1'b0); add(8'd4, 1'b1, 1'b0);
    test_latency("swap");
  endtask

  task automatic test_single();
    clear_stim();
    add(8'hC6, 1'b1, 1'b1);
    test_latency("single");
  endtask

  task automatic test_split();
    clear_stim();
    for (int i = 0; i < DEPTH + 2; i++) begin
      add(8'(i), i == DEPTH + 1, (i == 0) ? 1'b0 : (i == DEPTH) ? 1'b1 : 1'($urandom_range(1)));
    end
    run_stream("split", 100, -1);
    clear_stim();
    for (int i = 0; i < DEPTH; i++) begin
      add(8'($urandom), i == DEPTH - 1, 1'b1);
    end
    run_stream("full_with_last", 100, -1);
  endtask

  task automatic test_backpressure();
    clear_stim();
    for (int i = 0; i < 4; i++) add(8'($urandom), i == 3, 1'b1);
    run_stream("backpressure", 100, 2);
  endtask

  task automatic test_reset_drain();
    clear_stim();
    for (int i = 0; i < 4; i++) add(8'h10 + 8'(i), i == 3, 1'b0);
    build_expect();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b1.in_valid = 1'b1; b1.in_data = s_data[i]; b1.in_last = s_last[i]; b1.in_swap = s_swap[i];
    end
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.out_ready = 1'b1;
    total++;
    if ({b1.out_valid, b1.out_data} !== {1'b1, e1[0]}) begin
      bad++;
      $display("FAIL rst_drain first_out: got v=%b d=%h want v=1 d=%h", b1.out_valid, b1.out_data, e1[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    b1.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({b1.out_valid, b1.out_last, b1.in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL rst_drain abandon: got vld/last/rdy=%b want 000", {b1.out_valid, b1.out_last, b1.in_ready});
    end
    rst = 1'b0;
    #1;
    total++;
    if (b1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_drain ready: got %b want 1", b1.in_ready);
    end
    clear_stim();
    add(8'h5A, 1'b1, 1'b0);
    test_latency("rst_drain_fresh");
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      n = $urandom_range(DEPTH + 3, 1);
      for (int i = 0; i < n; i++) begin
        add(8'($urandom), (i == n - 1) || ($urandom_range(99) < 15), 1'($urandom_range(1)));
      end
      run_stream("random", 55, $urandom_range(n - 1));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_swap();
    test_single();
    test_split();
    test_backpressure();
    test_reset_drain();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reverse_burst.md
# reverse_burst

Streaming order reverser: accepts bursts of up to D words on a valid/ready input, stores them in an internal stack, then emits them last-in-first-out. Each word can optionally have its G-bit groups reversed. Sits in the logic library alongside the combinational bit reverser and is used on datapaths that need word-order and bit-order reversal together, such as LSB-first serial framing and FFT index reordering.

## Interface

- W, 8: data word width in bits.
- D, 16: stack depth, i.e. the maximum burst length in words; must be at least 2.
- G, 1: group width in bits for in-word reversal; must divide W. G=1 gives a pure bit reverse, G=8 gives a byte swap.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept an input word.
- in_data  in  W  input word.
- in_last  in  1  marks the final word of a burst.
- in_swap  in  1  group-reversal enable; sampled on the first word of each burst.
- out_valid  out  1  output word present.
- out_ready  in  1  sink accepts the output word.
- out_data  out  W  output word.
- out_last  out  1  marks the final word of an output burst.

## Operation

- State machine with two states: FILL and DRAIN. Reset enters FILL with count=0 and swap=0.
- FILL:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, in_data is written to stack[count] and count increments.
  - If this is the first word of the burst (count==0), in_swap is latched into swap.
  - Transition to DRAIN when the accepted word has in_last=1, or when count reaches D. The second case is a forced split: the next input word starts a new burst, and that burst latches in_swap afresh.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - out_data = stack[count-1], group-reversed when swap=1.
  - out_last=1 exactly when count==1.
  - On out_valid&&out_ready, count decrements. When the word with out_last is taken, the next state is FILL.
- Group reversal: output group k (bits [k*G+G-1 : k*G]) = stored group W/G-1-k; bit order inside each group is preserved.
- swap is applied at the output, not at write time. A single swap flag covers the whole burst.
- Widths: count is $clog2(D+1) bits and never exceeds D. Storage is a D×W register array; contents are not cleared by reset.
- Input and output never overlap: there is no acceptance while draining and no output while filling.
- A burst holds at least one word, so an empty burst cannot occur.

## Timing

- Reset values: in_ready=0 while reset is high and 1 in the first cycle after it is released. out_valid=0 and out_last=0. out_data is don't-care while out_valid=0.
- Latency: the cycle after the last word is accepted, out_valid=1 and out_data is that last word. For a burst of N words, N output transfers follow at one per cycle while out_ready is held high. The block returns to FILL (in_ready=1) the cycle after the out_last transfer.
- Throughput: a burst of N words takes 2N cycles with both sides always ready.
- Backpressure: with out_ready=0, out_data, out_last and out_valid stay stable until the transfer completes.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- A reset asserted mid-operation, in either state, abandons the burst. The next cycle is FILL with count=0, and no partial output follows.
- in_last presented together with the D-th word produces a single burst of D words, not a burst followed by an empty one.

## Test plan

- Reset, then push 3,1,4 (W=8, G=1, swap=0, last on 4) with out_ready=1: output 4,1,3 with out_last on 3. Output begins 1 cycle after 4 is accepted; in_ready returns 1 the cycle after.
- Same burst with swap=1: output 0x20,0x80,0xC0 (bit-reversed 4,1,3). With G=4 instead, output 0x40,0x10,0x30.
- Push D+2 words 0..D+1 with last only on the final word: first burst outputs D-1..0 with out_last on 0, second burst outputs D+1,D. in_swap is sampled separately for each burst.
- Hold out_ready=0 for 5 cycles mid-drain: out_data and out_last stay stable, and no word is lost or repeated.
- Assert reset during DRAIN after 1 of 4 words is output: out_valid=0 the next cycle, in_ready=1 after release, and a fresh single-word burst 0x5A is output as 0x5A with out_last=1.
- Single-word burst with in_last on the first word: exactly one output transfer with out_last=1, and the block is back in FILL 2 cycles after acceptance.
